queue_drain_scheduler: RTL and testbench

- Shares one Queue instance among NUM_REQ producers: a round-robin arbiter issues at most one write per cycle.
- Drains the queue to one downstream stream consumer in bursts. A burst starts on the fill threshold, an idle timeout, or a flush request.
- Sits between the monitor capture sources and the Queue/HPSPBRAM pair. It is the only block that drives the queue's valueIn, valueInValid and consumed.

---
 rtl/queue_drain_scheduler.sv | 135 +++++++++++++
 tb/tb_queue_drain_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_drain_scheduler.sv
// Shares one queue among NUM_REQ producers (round-robin writes) and drains it downstream in bursts.
// Latency: write accept is combinational; first drained word is valid 2 cycles after the trigger.
// Backpressure: producers stall when the queue is full; drain holds in PRESENT while out_ready is low.
module queue_drain_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_SIZE     = 32,
    parameter int QUEUE_LENGTH  = 4,
    parameter int REGISTER_SIZE = 32,
    parameter int MAX_BURST     = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [REGISTER_SIZE-1:0]       cfg_threshold,
    input  logic [REGISTER_SIZE-1:0]       cfg_timeout,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_SIZE-1:0]           q_value_in,
    output logic                           q_value_in_valid,
    output logic                           q_consumed,
    input  logic [DATA_SIZE-1:0]           q_value_out,
    input  logic                           q_empty,
    input  logic [$clog2(QUEUE_LENGTH):0]  q_counter,
    output logic                           out_valid,
    output logic [DATA_SIZE-1:0]           out_data,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           busy
);
    localparam int CNT_W = $clog2(QUEUE_LENGTH) + 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int REM_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         rr_ptr, winner, rr_nxt, idx;
    logic [REGISTER_SIZE-1:0] age, thr_eff;
    logic [REM_W-1:0]         remaining, rem_nxt, burst_len;
    logic                     flush_pending;
    logic                     any_req, space, accept;
    logic                     thr_hit, tmo_hit, trigger;

    // Scan downward so the closest valid port at or after rr_ptr wins last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // Full means no write, even if a pop happens this cycle.
    assign space  = (q_counter < CNT_W'(QUEUE_LENGTH));
    assign accept = reset && space && any_req;
    assign rr_nxt = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    assign req_ready        = accept ? (NUM_REQ'(1) << winner) : '0;
    assign q_value_in_valid = accept;
    assign q_value_in       = accept ? req_data[winner*DATA_SIZE +: DATA_SIZE] : '0;

    assign thr_eff = (cfg_threshold == '0) ? REGISTER_SIZE'(1) : cfg_threshold;
    assign thr_hit = (REGISTER_SIZE'(q_counter) >= thr_eff);
    assign tmo_hit = (cfg_timeout != '0) && (age >= cfg_timeout);
    assign trigger = (state == IDLE) && !q_empty && (thr_hit || flush_pending || tmo_hit);

    assign burst_len = (int'(q_counter) >= MAX_BURST) ? REM_W'(MAX_BURST) : REM_W'(q_counter);

    assign busy = (state != IDLE) || flush_pending;

    always_comb begin
        state_nxt  = state;
        rem_nxt    = remaining;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        q_consumed = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    rem_nxt   = burst_len;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = PRESENT;
            PRESENT: begin
                out_valid = 1'b1;
                out_data  = q_value_out;
                out_last  = (remaining == REM_W'(1));
                if (out_ready) begin
                    q_consumed = 1'b1;
                    if (remaining == REM_W'(1)) begin
                        state_nxt = IDLE;
                    end else begin
                        rem_nxt   = remaining - 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            remaining     <= '0;
            rr_ptr        <= '0;
            age           <= '0;
            flush_pending <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            if (accept) begin
                rr_ptr <= rr_nxt;
            end
            if (trigger || q_empty) begin
                age <= '0;
            end else if ((state == IDLE) && (age != '1)) begin
                age <= age + 1'b1;
            end
            if (flush) begin
                flush_pending <= 1'b1;
            end else if ((state == IDLE) && q_empty) begin
                flush_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_queue_drain_scheduler.sv
// Directed bench for queue_drain_scheduler with a small behavioural queue (registered read) attached.
module tb_queue_drain_scheduler;
    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  cfg_threshold, cfg_timeout;
    logic         flush;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  q_value_in;
    logic         q_value_in_valid, q_consumed;
    logic [31:0]  q_value_out;
    logic         q_empty;
    logic [2:0]   q_counter;
    logic         out_valid, out_last, out_ready, busy;
    logic [31:0]  out_data;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;

    always #5 clock = ~clock;

    queue_drain_scheduler dut (
        .clock(clock), .reset(reset),
        .cfg_threshold(cfg_threshold), .cfg_timeout(cfg_timeout), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .q_value_in(q_value_in), .q_value_in_valid(q_value_in_valid), .q_consumed(q_consumed),
        .q_value_out(q_value_out), .q_empty(q_empty), .q_counter(q_counter),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy)
    );

    // Queue stand-in: 4 entries, valueOut registered from the current head every cycle.
    assign q_empty = (q_counter == 3'd0);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_counter   <= '0;
            q_value_out <= '0;
        end else begin
            if (q_value_in_valid) begin
                mem[wr_ptr] <= q_value_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (q_consumed) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            q_value_out <= mem[rd_ptr];
            q_counter   <= q_counter + 3'(q_value_in_valid) - 3'(q_consumed);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rst_pulse();
        reset     = 1'b0;
        req_valid = 4'b0000;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        cfg_threshold = 32'd3;
        cfg_timeout   = 32'd0;
        flush         = 1'b0;
        req_valid     = 4'b1111;
        req_data      = '0;
        out_ready     = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_vin_valid", 32'(q_value_in_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req_valid = 4'b0000;
        step();
        reset = 1'b1;

        // Three writes from port 1, then a 3-word burst at 1 word per 2 cycles.
        req_valid = 4'b0010;
        req_data[63:32] = 32'hA1;
        #1 chk("t1_rdy_a1", 32'(req_ready), 32'h2);
        chk("t1_vin_a1", q_value_in, 32'hA1);
        chk("t1_vld_a1", 32'(q_value_in_valid), 32'h1);
        step();
        req_data[63:32] = 32'hA2;
        #1 chk("t1_rdy_a2", 32'(req_ready), 32'h2);
        step();
        req_data[63:32] = 32'hA3;
        #1 chk("t1_rdy_a3", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        #1 chk("t1_idle_valid", 32'(out_valid), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        step();
        chk("t1_fetch_valid", 32'(out_valid), 32'h0);
        chk("t1_fetch_busy", 32'(busy), 32'h1);
        step();
        chk("t1_w0_valid", 32'(out_valid), 32'h1);
        chk("t1_w0_data", out_data, 32'hA1);
        chk("t1_w0_last", 32'(out_last), 32'h0);
        chk("t1_w0_cons", 32'(q_consumed), 32'h1);
        step();
        chk("t1_gap_valid", 32'(out_valid), 32'h0);
        step();
        chk("t1_w1_data", out_data, 32'hA2);
        chk("t1_w1_last", 32'(out_last), 32'h0);
        step();
        step();
        chk("t1_w2_data", out_data, 32'hA3);
        chk("t1_w2_last", 32'(out_last), 32'h1);
        step();
        chk("t1_end_empty", 32'(q_empty), 32'h1);
        chk("t1_end_busy", 32'(busy), 32'h0);
        chk("t1_end_valid", 32'(out_valid), 32'h0);

        // All ports valid while draining: grants 0,1,2,3,0 then queue full.
        rst_pulse();
        cfg_threshold = 32'd1;
        req_valid = 4'b1111;
        req_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        for (int k = 0; k < 5; k++) begin
            #1 chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
            chk("t2_vin", q_value_in, 32'hB0 + 32'(k % 4));
            step();
        end
        chk("t2_full_rdy", 32'(req_ready), 32'h0);
        chk("t2_full_vld", 32'(q_value_in_valid), 32'h0);

        // Threshold unreachable; timeout of 5 forces a 1-word burst.
        rst_pulse();
        cfg_threshold = 32'd8;
        cfg_timeout   = 32'd5;
        req_valid = 4'b0100;
        req_data[95:64] = 32'hC5;
        #1 chk("t3_rdy", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            #1 chk("t3_wait_busy", 32'(busy), 32'h0);
            step();
        end
        chk("t3_fetch_busy", 32'(busy), 32'h1);
        chk("t3_fetch_valid", 32'(out_valid), 32'h0);
        step();
        chk("t3_data", out_data, 32'hC5);
        chk("t3_last", 32'(out_last), 32'h1);
        step();
        chk("t3_empty", 32'(q_empty), 32'h1);
        chk("t3_busy_end", 32'(busy), 32'h0);
        cfg_timeout = 32'd0;

        // Flush with 2 words below threshold 4.
        rst_pulse();
        cfg_threshold = 32'd4;
        req_valid = 4'b0001;
        req_data[31:0] = 32'hD0;
        #1 chk("t4_rdy_d0", 32'(req_ready), 32'h1);
        step();
        req_data[31:0] = 32'hD1;
        #1 chk("t4_rdy_d1", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        flush = 1'b1;
        #1 chk("t4_busy_pre", 32'(busy), 32'h0);
        step();
        flush = 1'b0;
        #1 chk("t4_busy_pend", 32'(busy), 32'h1);
        step();
        chk("t4_fetch_valid", 32'(out_valid), 32'h0);
        step();
        chk("t4_w0_data", out_data, 32'hD0);
        chk("t4_w0_last", 32'(out_last), 32'h0);
        step();
        step();
        chk("t4_w1_data", out_data, 32'hD1);
        chk("t4_w1_last", 32'(out_last), 32'h1);
        step();
        chk("t4_empty", 32'(q_empty), 32'h1);
        chk("t4_busy_drain", 32'(busy), 32'h1);
        step();
        chk("t4_busy_clear", 32'(busy), 32'h0);

        // Downstream stall for 4 cycles, then exactly one pop.
        rst_pulse();
        cfg_threshold = 32'd1;
        out_ready = 1'b0;
        req_valid = 4'b1000;
        req_data[127:96] = 32'hE7;
        #1 chk("t5_rdy_e7", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b0000;
        step();
        step();
        req_valid = 4'b0001;
        req_data[31:0] = 32'hF0;
        #1 chk("t5_rdy_f0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t5_stall_valid", 32'(out_valid), 32'h1);
            chk("t5_stall_data", out_data, 32'hE7);
            chk("t5_stall_cons", 32'(q_consumed), 32'h0);
            chk("t5_stall_last", 32'(out_last), 32'h1);
            step();
            req_valid = 4'b0000;
        end
        out_ready = 1'b1;
        #1 chk("t5_pop", 32'(q_consumed), 32'h1);
        chk("t5_pop_data", out_data, 32'hE7);
        step();
        out_ready = 1'b0;
        #1 chk("t5_after_cons", 32'(q_consumed), 32'h0);
        chk("t5_after_valid", 32'(out_valid), 32'h0);
        step();
        step();
        chk("t5_next_valid", 32'(out_valid), 32'h1);
        chk("t5_next_data", out_data, 32'hF0);

        // Reset asserted in PRESENT drops everything at once.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        reset = 1'b0;
        #1 chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_cons", 32'(q_consumed), 32'h0);
        chk("t6_rst_rdy", 32'(req_ready), 32'h0);
        chk("t6_rst_vld", 32'(q_value_in_valid), 32'h0);
        step();
        reset = 1'b1;
        #1 chk("t6_post_rdy", 32'(req_ready), 32'h1);
        chk("t6_post_valid", 32'(out_valid), 32'h0);
        chk("t6_post_busy", 32'(busy), 32'h0);
        req_valid = 4'b0000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
